// File: rtl/sfp_div_seq.sv
// Sequential normaliser: divides DEPTH buffered elements by a common divisor
// through one external divider. Optional zero-element bypass: SFP_DIV_SEQ_ZERO_BYPASS_EN.
module sfp_div_seq #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [DATA_W-1:0] sum,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              div_start,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    input  logic              div_busy,
    input  logic              div_done,
    input  logic              div_valid,
    input  logic [DATA_W-1:0] div_val,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err_div0
);

    typedef enum logic [2:0] {
        IDLE, READ, WAIT_RD, ISSUE, WAIT_DIV, WRITE, FIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [DATA_W-1:0] sum_reg;
    logic [DATA_W-1:0] elem_reg;
    logic [DATA_W-1:0] res_reg;

    // The divider's busy flag carries no information the FSM needs.
    logic unused_div_busy;
    assign unused_div_busy = div_busy;

    assign rd_addr = idx_reg;
    assign wr_addr = idx_reg;
    assign wr_data = res_reg;
    assign div_a   = elem_reg;
    assign div_b   = sum_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            sum_reg   <= '0;
            elem_reg  <= '0;
            res_reg   <= '0;
            rd_en     <= 1'b0;
            div_start <= 1'b0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_div0  <= 1'b0;
        end else begin
            rd_en     <= 1'b0;
            div_start <= 1'b0;
            wr_en     <= 1'b0;
            done      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (go) begin
                        sum_reg   <= sum;
                        err_div0  <= 1'b0;
                        idx_reg   <= '0;
                        busy      <= 1'b1;
                        rd_en     <= 1'b1;
                        state_reg <= READ;
                    end
                end
                READ: begin
                    state_reg <= WAIT_RD;
                end
                WAIT_RD: begin
                    elem_reg <= rd_data;
`ifdef SFP_DIV_SEQ_ZERO_BYPASS_EN
                    // A zero element over a nonzero divisor is known to yield 0.
                    if (rd_data == '0 && sum_reg != '0) begin
                        res_reg   <= '0;
                        wr_en     <= 1'b1;
                        state_reg <= WRITE;
                    end else begin
                        div_start <= 1'b1;
                        state_reg <= ISSUE;
                    end
`else
                    div_start <= 1'b1;
                    state_reg <= ISSUE;
`endif
                end
                ISSUE: begin
                    state_reg <= WAIT_DIV;
                end
                WAIT_DIV: begin
                    // div_done is only trusted here; earlier it may be stale.
                    if (div_done) begin
                        if (div_valid) begin
                            res_reg <= div_val;
                        end else begin
                            res_reg  <= '1;
                            err_div0 <= 1'b1;
                        end
                        wr_en     <= 1'b1;
                        state_reg <= WRITE;
                    end
                end
                WRITE: begin
                    if (idx_reg == LAST_IDX) begin
                        done      <= 1'b1;
                        state_reg <= FIN;
                    end else begin
                        idx_reg   <= idx_reg + 1'b1;
                        rd_en     <= 1'b1;
                        state_reg <= READ;
                    end
                end
                FIN: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sfp_div_seq.md
Name: sfp_div_seq

Overview:
- Initiator-side controller for the SFP sequential divider. It drives the divider's start/a/b request and consumes its busy/done/valid/val response.
- Normalises a vector of DEPTH unsigned elements held in an SFP buffer by a common divisor (e.g. a softmax exp-sum): reads each element, issues one divide, writes the quotient back to an output buffer, then pulses done.
- Sits between the SFP element buffer and one divider instance.

Parameters:
- DEPTH, 8, number of elements per run.
- ADDR_W, 3, buffer address width; must satisfy 2**ADDR_W >= DEPTH.
- DATA_W, 20, element, divisor and quotient width; must match the divider.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- go  input  1  start a run; sampled only in IDLE.
- sum  input  DATA_W  divisor; latched on accepted go.
- rd_en  output  1  element buffer read strobe.
- rd_addr  output  ADDR_W  element read address.
- rd_data  input  DATA_W  element data; valid the cycle after rd_en.
- div_start  output  1  one-cycle divider start.
- div_a  output  DATA_W  dividend to the divider.
- div_b  output  DATA_W  divisor to the divider.
- div_busy  input  1  divider busy; informational only.
- div_done  input  1  divider done, level; held until the next start.
- div_valid  input  1  divider result valid; 0 on divide-by-zero.
- div_val  input  DATA_W  divider quotient.
- wr_en  output  1  result write strobe.
- wr_addr  output  ADDR_W  result address, equal to the element index.
- wr_data  output  DATA_W  result data.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.
- err_div0  output  1  sticky: at least one divide-by-zero in the last run; cleared on accepted go.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, index 0, latched divisor 0. Reset wins over go and over any in-flight divide.
- FSM states: IDLE, READ, WAIT_RD, ISSUE, WAIT_DIV, WRITE, FIN.
- IDLE: on go, latch sum into sum_q, clear err_div0, set idx=0 and busy=1, go to READ. Otherwise stay.
- READ, 1 cycle: rd_en=1, rd_addr=idx. Go to WAIT_RD.
- WAIT_RD, 1 cycle: capture rd_data into elem_q. Go to ISSUE.
- ISSUE, 1 cycle: div_start=1. Go to WAIT_DIV.
- div_a and div_b: driven continuously from elem_q and sum_q. They are stable from ISSUE through the end of WAIT_DIV.
- WAIT_DIV: wait for div_done=1. div_done is ignored in every other state, because it is stale from the previous operation until the ISSUE edge.
  - div_done=1 and div_valid=1: capture div_val into res_q.
  - div_done=1 and div_valid=0: capture all-ones into res_q and set err_div0.
  - Either case: go to WRITE.
- WRITE, 1 cycle: wr_en=1, wr_addr=idx, wr_data=res_q.
  - idx==DEPTH-1: go to FIN.
  - Otherwise: idx+1, go to READ.
- FIN, 1 cycle: done=1, busy=0 from the next cycle, go to IDLE.
- Latency: the divider returns done 10 cycles after the ISSUE edge, so each element takes 14 cycles. go to done pulse is DEPTH*14+1 cycles (113 for DEPTH=8).
- Variable divider latency: the FSM waits in WAIT_DIV indefinitely; there is no timeout.
- Arithmetic: unsigned. The quotient is truncated by the divider; no rounding or scaling here.
- Wrap: idx never exceeds DEPTH-1. wr_addr and rd_addr stay in range.
- Simultaneous events: go while busy is ignored. rst mid-run aborts with no further rd_en, div_start or wr_en. The divider may still complete; its done is ignored.
- Strobes: rd_en, div_start, wr_en and done are never high in the same cycle.

Optional Feature:
- Macro: SFP_DIV_SEQ_ZERO_BYPASS_EN.
- Defined:
  - In WAIT_RD, if rd_data==0 and sum_q!=0, skip ISSUE and WAIT_DIV and go directly to WRITE with res_q=0.
  - No div_start is issued; the element costs 3 cycles instead of 14.
  - If sum_q==0, the divide-by-zero path applies as normal.
- Not defined: every element goes through the divider, with uniform 14-cycle timing.

Test Plan:
- sum=7, mem[k]=100*(k+1) for k=0..7, go pulse -> wr_data sequence 14,28,42,57,71,85,100,114 at wr_addr 0..7; exactly 8 div_start pulses; done pulse 113 cycles after go; err_div0=0.
- sum=0, any data -> eight writes of 20'hFFFFF; err_div0=1 after run; next run with sum=1 clears err_div0 at go.
- Divider model with 25-cycle latency and stale div_done held high before ISSUE -> no early capture; results correct; exactly one wr_en per element.
- mem[k]=3, sum=5 -> all wr_data=0. A go pulse during busy is ignored, so only one done pulse occurs.
- rst asserted in WAIT_DIV of element 3 -> busy=0 next cycle; no further wr_en. Next go restarts at rd_addr=0 and writes all 8 results correctly.
- With SFP_DIV_SEQ_ZERO_BYPASS_EN defined, mem[2]=0, sum=9 -> wr_data[2]=0, 7 div_start pulses, done at 8*14+1-11=102 cycles after go. Without the macro: 8 pulses, done at 113 cycles.
